display_value_fifo: RTL and testbench



---
 rtl/display_value_fifo_if.sv | 24 ++
 rtl/display_value_fifo.sv | 71 +++++++
 tb/tb_display_value_fifo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/display_value_fifo_if.sv
// Handshake bundle between the style/value resolver (master) and the
// display-value FIFO (slave); carries both the push and the pop side.
interface display_value_fifo_if #(
  parameter int WIDTH = 59
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             is_primitive_value;
  logic             is_valid_display_value;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, is_primitive_value, is_valid_display_value, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, is_primitive_value, is_valid_display_value, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/display_value_fifo.sv
// DEPTH-entry circular FIFO for qualified display values with a saturating
// reject counter. Define DISPLAY_FIFO_BYPASS_EN for zero-latency pass-through when empty.
module display_value_fifo #(
  parameter int WIDTH = 59,
  parameter int DEPTH = 4,
  parameter int REJ_W = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  display_value_fifo_if.slave          bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [REJ_W-1:0]             reject_count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [REJ_W-1:0] reject_reg;

  logic ld_en, empty, full, bypass, push, pop;

  assign ld_en = bus.is_primitive_value & bus.is_valid_display_value;
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));

`ifdef DISPLAY_FIFO_BYPASS_EN
  // Empty FIFO with a ready consumer: hand the offer straight through, never stored.
  assign bypass = empty & bus.in_valid & ld_en & bus.out_ready & ~reset;
`else
  assign bypass = 1'b0;
`endif

  // No push-through when full: in_ready ignores out_ready.
  assign push = bus.in_valid & ld_en & ~full & ~bypass;
  assign pop  = ~empty & bus.out_ready;

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty | bypass;
  assign bus.out_data  = bypass ? bus.in_data
                       : (~empty ? storage[rd_ptr_reg] : '0);

  assign count        = count_reg;
  assign reject_count = reject_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      reject_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      // Unqualified offers are counted regardless of in_ready; saturate, never wrap.
      if (bus.in_valid & ~ld_en & (reject_reg != '1))
        reject_reg <= reject_reg + REJ_W'(1);
    end
  end

  // Storage is left unreset; it is masked by out_valid until written.
  always_ff @(posedge clock) begin
    if (push) storage[wr_ptr_reg] <= bus.in_data;
  end
endmodule

// File: tb/tb_display_value_fifo.sv
// Directed self-checking bench for display_value_fifo (DEPTH=4, REJ_W=8).
module tb_display_value_fifo;
  localparam int WIDTH = 59;
  localparam int DEPTH = 4;
  localparam int REJ_W = 8;

  logic                        clock;
  logic                        reset;
  logic [$clog2(DEPTH+1)-1:0]  count;
  logic [REJ_W-1:0]            reject_count;

  int total = 0;
  int bad   = 0;

  display_value_fifo_if #(.WIDTH(WIDTH)) bus ();

  display_value_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REJ_W(REJ_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .count        (count),
    .reject_count (reject_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[%0t] FAIL %s: got=%0h expected=%0h", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s: %0h", $time, tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.is_primitive_value = 1'b1;
    bus.is_valid_display_value = 1'b1;
    bus.out_ready = 1'b0;
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_reject", 64'(reject_count), 64'd0);
    reset = 1'b0;
    tick();

    // Fill to full with the consumer stalled, then hold a fifth offer.
    bus.in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.in_data = WIDTH'(k);
      tick();
    end
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_data = WIDTH'(5);
    tick();
    tick();
    check("held_count", 64'(count), 64'd4);
    check("held_head", 64'(bus.out_data), 64'h1);

    // Drain; the held 0x5 enters only after the first pop frees a slot.
    bus.out_ready = 1'b1;
    check("drain_1", 64'(bus.out_data), 64'h1);
    tick();
    check("drain_2", 64'(bus.out_data), 64'h2);
    check("drain_cnt_a", 64'(count), 64'd3);
    tick();
    bus.in_valid = 1'b0;
    check("drain_3", 64'(bus.out_data), 64'h3);
    check("drain_cnt_b", 64'(count), 64'd3);
    tick();
    check("drain_4", 64'(bus.out_data), 64'h4);
    tick();
    check("drain_5", 64'(bus.out_data), 64'h5);
    tick();
    check("drain_empty_cnt", 64'(count), 64'd0);
    check("drain_empty_valid", 64'(bus.out_valid), 64'd0);
    check("drain_empty_data", 64'(bus.out_data), 64'd0);
    bus.out_ready = 1'b0;

    // Unqualified offers: counted, never stored; counter saturates.
    bus.in_valid = 1'b1;
    bus.in_data = WIDTH'(12'hABC);
    bus.is_valid_display_value = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rej_count_occ", 64'(count), 64'd0);
    check("rej_3", 64'(reject_count), 64'd3);
    check("rej_out_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 300; i++) tick();
    check("rej_sat", 64'(reject_count), 64'd255);
    bus.is_valid_display_value = 1'b1;

    // Reset mid-traffic: 3 entries, reset asserted between edges.
    for (int k = 0; k < 3; k++) begin
      bus.in_data = WIDTH'(8'h20 + k);
      tick();
    end
    bus.in_valid = 1'b0;
    check("pre_rst_count", 64'(count), 64'd3);
    #3 reset = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_out_data", 64'(bus.out_data), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_reject", 64'(reject_count), 64'd0);
    reset = 1'b0;
    tick();

    // Steady push+pop at count=2; pointers wrap several times.
    bus.in_valid = 1'b1;
    bus.in_data = WIDTH'(8'h10);
    tick();
    bus.in_data = WIDTH'(8'h11);
    tick();
    check("pp_start_cnt", 64'(count), 64'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = WIDTH'(8'h12 + i);
      check($sformatf("pp_head_%0d", i), 64'(bus.out_data), 64'(8'h10 + i));
      tick();
      check($sformatf("pp_cnt_%0d", i), 64'(count), 64'd2);
    end
    bus.in_valid = 1'b0;
    check("pp_tail_a", 64'(bus.out_data), 64'h1A);
    tick();
    check("pp_tail_b", 64'(bus.out_data), 64'h1B);
    tick();
    check("pp_end_cnt", 64'(count), 64'd0);

`ifdef DISPLAY_FIFO_BYPASS_EN
    // Empty with ready consumer: same-cycle pass-through, nothing stored.
    bus.in_valid = 1'b1;
    bus.in_data = WIDTH'(8'h77);
    #1;
    check("byp_out_valid", 64'(bus.out_valid), 64'd1);
    check("byp_out_data", 64'(bus.out_data), 64'h77);
    check("byp_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    #1;
    check("byp_count", 64'(count), 64'd0);
    check("byp_after_valid", 64'(bus.out_valid), 64'd0);
`else
    // Empty with ready consumer: one-cycle latency, count back to 0 after.
    bus.in_valid = 1'b1;
    bus.in_data = WIDTH'(8'h55);
    #1;
    check("lat_n_valid", 64'(bus.out_valid), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    check("lat_n1_valid", 64'(bus.out_valid), 64'd1);
    check("lat_n1_data", 64'(bus.out_data), 64'h55);
    check("lat_n1_count", 64'(count), 64'd1);
    tick();
    check("lat_n2_count", 64'(count), 64'd0);
    check("lat_n2_valid", 64'(bus.out_valid), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
